// File: rtl/call_stack.sv
// Return-address stack for CALL/RET with occupancy and sticky error flags.
// Optional build macro CALL_STACK_WRAP_EN: a push on full overwrites the oldest entry instead of being dropped.
module call_stack #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] top_idx;

  assign top_idx   = sp_q - ADDR_WIDTH'(1);
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_CNT);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign data_out  = empty ? '0 : mem_q[top_idx];

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = sp_q;

    // A new error raised below overrides the clear in the same cycle.
    if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    if (enable) begin
      if (push && pop && !empty) begin
        we    = 1'b1;
        waddr = top_idx;
      end else if (push) begin
        if (!full) begin
          we      = 1'b1;
          sp_d    = sp_q + ADDR_WIDTH'(1);
          count_d = count_q + (ADDR_WIDTH + 1)'(1);
        end else begin
          overflow_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
          we   = 1'b1;
          sp_d = sp_q + ADDR_WIDTH'(1);
`endif
        end
      end else if (pop) begin
        if (!empty) begin
          sp_d    = top_idx;
          count_d = count_q - (ADDR_WIDTH + 1)'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem_q[waddr] <= data_in;
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack (depth 4) with a queue-based reference model checked every cycle.
module tb_call_stack;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          clear_err = 1'b0;
  logic [DW-1:0] data_out;
  logic          empty, full, overflow, underflow;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  logic [31:0] stk[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  call_stack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .push(push), .pop(pop),
    .data_in(data_in), .clear_err(clear_err), .data_out(data_out),
    .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stack is a queue whose back is the top entry.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (clear_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (enable) begin
        if (push && pop && stk.size() > 0) begin
          stk[stk.size()-1] = data_in;
        end else if (push) begin
          if (stk.size() < DEPTH) begin
            stk.push_back(data_in);
          end else begin
            m_ovf = 1'b1;
`ifdef CALL_STACK_WRAP_EN
            void'(stk.pop_front());
            stk.push_back(data_in);
`endif
          end
        end else if (pop) begin
          if (stk.size() > 0) void'(stk.pop_back());
          else m_unf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_count", 32'(count), 32'(stk.size()));
      chk("cyc_data_out", data_out, (stk.size() > 0) ? stk[stk.size()-1] : 32'h0);
      chk("cyc_empty", 32'(empty), 32'(stk.size() == 0));
      chk("cyc_full", 32'(full), 32'(stk.size() == DEPTH));
      chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
      chk("cyc_underflow", 32'(underflow), 32'(m_unf));
    end
  end

  task automatic idle_inputs();
    enable = 1'b0; push = 1'b0; pop = 1'b0; clear_err = 1'b0; data_in = '0;
  endtask

  // Drive one cycle of inputs, let the edge sample them, then return 1 time unit after it.
  task automatic op(input logic e, input logic pu, input logic po, input logic [31:0] d, input logic ce);
    enable = e; push = pu; pop = po; data_in = d; clear_err = ce;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    logic [31:0] exp_pops [4];
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_en = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);

    op(1, 1, 0, 32'h100, 0);
    op(1, 1, 0, 32'h200, 0);
    op(1, 1, 0, 32'h300, 0);
    chk("push3_count", 32'(count), 32'd3);
    chk("push3_top", data_out, 32'h300);
    enable = 1; pop = 1; #1; chk("pop1_val", data_out, 32'h300); op(1, 0, 1, 0, 0);
    enable = 1; pop = 1; #1; chk("pop2_val", data_out, 32'h200); op(1, 0, 1, 0, 0);
    enable = 1; pop = 1; #1; chk("pop3_val", data_out, 32'h100); op(1, 0, 1, 0, 0);
    chk("pop3_empty", 32'(empty), 32'd1);
    chk("pop3_data_out", data_out, 32'h0);

    repeat (5) op(0, 1, 0, 32'h55, 0);
    chk("noen_count", 32'(count), 32'd0);
    chk("noen_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 5; i++) op(1, 1, 0, 32'hA + 32'(i), 0);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_full", 32'(full), 32'd1);
`ifdef CALL_STACK_WRAP_EN
    chk("ovf_top", data_out, 32'hE);
    exp_pops = '{32'hE, 32'hD, 32'hC, 32'hB};
`else
    chk("ovf_top", data_out, 32'hD);
    exp_pops = '{32'hD, 32'hC, 32'hB, 32'hA};
`endif
    for (int i = 0; i < 4; i++) begin
      enable = 1; pop = 1; #1;
      chk("ovf_pop_val", data_out, exp_pops[i]);
      op(1, 0, 1, 0, 0);
    end
    op(0, 0, 0, 0, 1);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    op(1, 0, 1, 0, 0);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    op(0, 0, 0, 0, 1);
    chk("unf_clear", 32'(underflow), 32'd0);
    op(1, 0, 1, 0, 1);
    chk("unf_wins_clear", 32'(underflow), 32'd1);
    op(1, 1, 1, 32'h77, 1);
    chk("pushpop_empty_count", 32'(count), 32'd1);
    chk("pushpop_empty_unf", 32'(underflow), 32'd0);
    chk("pushpop_empty_top", data_out, 32'h77);
    op(1, 0, 1, 0, 0);

    op(1, 1, 0, 32'h40, 0);
    op(1, 1, 0, 32'h44, 0);
    op(1, 1, 1, 32'h80, 0);
    chk("replace_count", 32'(count), 32'd2);
    chk("replace_top", data_out, 32'h80);
    op(1, 0, 1, 0, 0);
    chk("replace_pop_top", data_out, 32'h40);
    op(1, 0, 1, 0, 0);

    op(1, 1, 0, 32'h10, 0);
    op(1, 1, 0, 32'h20, 0);
    @(negedge clk);
    enable = 1; push = 1; data_in = 32'h30;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_data_out", data_out, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    op(0, 0, 0, 0, 0);
    chk("post_rst_count", 32'(count), 32'd0);
    op(1, 1, 0, 32'h99, 0);
    chk("post_rst_push", data_out, 32'h99);

    @(negedge clk);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
